// File: rtl/sram_rw_sequencer.sv
// Phase sequencer for the SRAM macro: precharge, wordline/bitline development,
// sense and capture for reads; precharge then driven write for writes.
module sram_rw_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int T_PRE   = 2,
    parameter int T_DEV   = 3,
    parameter int T_SENSE = 1,
    parameter int T_WR    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [$clog2(ROWS)-1:0] req_addr,
    input  logic [COLS-1:0]         req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [COLS-1:0]         rsp_rdata,
    output logic                    precharge_en,
    output logic [ROWS-1:0]         wl,
    output logic                    sae,
    output logic                    wr_drv_en,
    output logic [COLS-1:0]         bl_wdata,
    input  logic [COLS-1:0]         sa_dout,
    output logic                    busy
);

    localparam int AW    = $clog2(ROWS);
    localparam int TMAX1 = (T_PRE > T_DEV) ? T_PRE : T_DEV;
    localparam int TMAX2 = (T_SENSE > T_WR) ? T_SENSE : T_WR;
    localparam int TMAX  = (TMAX1 > TMAX2) ? TMAX1 : TMAX2;
    localparam int CW    = $clog2(TMAX + 1);
    localparam logic [AW:0] ROWS_V = ROWS[AW:0];

    typedef enum logic [2:0] {IDLE, PRE, DEV, SENSE, CAPT, WRITE, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] wdata_q;
    logic            addr_ok;
    logic            accept;
    logic [ROWS-1:0] row_sel;
    logic            wl_phase;
    logic            rsp_phase;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign addr_ok   = ({1'b0, addr_q} < ROWS_V);
    assign row_sel   = ROWS'(1) << addr_q;
    assign wl_phase  = (state_nxt == DEV) || (state_nxt == SENSE) || (state_nxt == WRITE);
    assign rsp_phase = (state_nxt == CAPT) || (state_nxt == DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PRE;
                    cnt_nxt   = CW'(T_PRE - 1);
                end
            end
            PRE: begin
                if (cnt == '0) begin
                    state_nxt = we_q ? WRITE : DEV;
                    cnt_nxt   = we_q ? CW'(T_WR - 1) : CW'(T_DEV - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DEV: begin
                if (cnt == '0) begin
                    state_nxt = SENSE;
                    cnt_nxt   = CW'(T_SENSE - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            SENSE: begin
                if (cnt == '0) state_nxt = CAPT;
                else           cnt_nxt   = cnt - CW'(1);
            end
            WRITE: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            CAPT:    state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Array controls are decoded from the next state so they come straight off flops.
    // sae is gated by a valid row so it never fires without a wordline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            precharge_en <= 1'b0;
            wl           <= '0;
            sae          <= 1'b0;
            wr_drv_en    <= 1'b0;
            bl_wdata     <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            precharge_en <= (state_nxt == PRE);
            wl           <= (wl_phase && addr_ok) ? row_sel : '0;
            sae          <= (state_nxt == SENSE) && addr_ok;
            wr_drv_en    <= (state_nxt == WRITE);
            bl_wdata     <= (state_nxt == WRITE) ? wdata_q : '0;
            rsp_valid    <= rsp_phase;
            rsp_err      <= rsp_phase && !addr_ok;
            if (state == SENSE && cnt == '0) begin
                rsp_rdata <= addr_ok ? sa_dout : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Bench for sram_rw_sequencer: three instances (defaults, all-ones timing, ROWS=12)
// checked every cycle against a phase-window model plus hand-computed literals.
module tb_sram_rw_sequencer;

    localparam int NI = 3;
    localparam int TP [NI] = '{2, 1, 2};
    localparam int TD [NI] = '{3, 1, 3};
    localparam int TS [NI] = '{1, 1, 1};
    localparam int TW [NI] = '{2, 1, 2};
    localparam int RW [NI] = '{16, 16, 12};

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0] req_valid = '0;
    logic          req_we = 1'b0;
    logic [3:0]    req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic [15:0]   sa_dout [NI];

    logic [NI-1:0] req_ready, rsp_valid, rsp_err, pre, sae, wrdrv, busy;
    logic [15:0]   rdata [NI];
    logic [15:0]   wl [NI];
    logic [15:0]   blw [NI];
    logic [11:0]   wl_small;

    assign wl[2] = {4'b0, wl_small};

    always #5 clk = ~clk;

    sram_rw_sequencer #(.ROWS(16), .COLS(16), .T_PRE(2), .T_DEV(3), .T_SENSE(1), .T_WR(2)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rdata[0]),
        .precharge_en(pre[0]), .wl(wl[0]), .sae(sae[0]), .wr_drv_en(wrdrv[0]),
        .bl_wdata(blw[0]), .sa_dout(sa_dout[0]), .busy(busy[0]));

    sram_rw_sequencer #(.ROWS(16), .COLS(16), .T_PRE(1), .T_DEV(1), .T_SENSE(1), .T_WR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rdata[1]),
        .precharge_en(pre[1]), .wl(wl[1]), .sae(sae[1]), .wr_drv_en(wrdrv[1]),
        .bl_wdata(blw[1]), .sa_dout(sa_dout[1]), .busy(busy[1]));

    sram_rw_sequencer #(.ROWS(12), .COLS(16), .T_PRE(2), .T_DEV(3), .T_SENSE(1), .T_WR(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_err(rsp_err[2]), .rsp_rdata(rdata[2]),
        .precharge_en(pre[2]), .wl(wl_small), .sae(sae[2]), .wr_drv_en(wrdrv[2]),
        .bl_wdata(blw[2]), .sa_dout(sa_dout[2]), .busy(busy[2]));

    // Model: k = cycles since accept (0 = idle); every output is a window on k.
    int          k [NI];
    logic        m_we [NI];
    logic [3:0]  m_addr [NI];
    logic [15:0] m_wdata [NI];
    logic [15:0] m_rdata [NI];
    logic [15:0] mem [NI][16];
    int          cyc = 0;
    int          acc_cyc [NI] = '{default: 0};
    int          acc_n [NI] = '{default: 0};

    function automatic int lat(input int i, input logic we);
        return we ? TP[i] + TW[i] + 1 : TP[i] + TD[i] + TS[i] + 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                k[i]       <= 0;
                m_we[i]    <= 1'b0;
                m_addr[i]  <= '0;
                m_wdata[i] <= '0;
                m_rdata[i] <= '0;
                for (int r = 0; r < 16; r++) mem[i][r] <= (r < RW[i]) ? 16'h0000 : 16'hDEAD;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cyc[i] <= cyc;
                    acc_n[i]   <= acc_n[i] + 1;
                end
                if (k[i] == 0) begin
                    if (req_valid[i]) begin
                        k[i]       <= 1;
                        m_we[i]    <= req_we;
                        m_addr[i]  <= req_addr;
                        m_wdata[i] <= req_wdata;
                    end
                end else begin
                    k[i] <= (k[i] == lat(i, m_we[i])) ? 0 : k[i] + 1;
                    if (!m_we[i] && k[i] == TP[i] + TD[i] + TS[i])
                        m_rdata[i] <= (int'(m_addr[i]) < RW[i]) ? mem[i][m_addr[i]] : 16'h0000;
                    if (m_we[i] && k[i] == TP[i] + TW[i] && int'(m_addr[i]) < RW[i])
                        mem[i][m_addr[i]] <= m_wdata[i];
                end
            end
        end
    end

    // Sense amps present the true row only in the last SENSE cycle, inverted otherwise.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            if (!m_we[i] && k[i] == TP[i] + TD[i] + TS[i]) sa_dout[i] = mem[i][m_addr[i]];
            else                                         sa_dout[i] = ~mem[i][m_addr[i]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int pre_cyc [NI] = '{default: 0};
    int wl_cyc [NI] = '{default: 0};
    int sae_cyc [NI] = '{default: 0};
    int saeok_cyc [NI] = '{default: 0};
    int wr_cyc [NI] = '{default: 0};
    int pat_cyc [NI] = '{default: 0};
    int rsp_seen [NI] = '{default: 0};
    int rsp_cyc [NI] = '{default: 0};
    logic [NI-1:0] err_last = '0;
    int s_pre, s_wl, s_sae, s_saeok, s_wr, s_pat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap(input int i);
        s_pre = pre_cyc[i]; s_wl = wl_cyc[i]; s_sae = sae_cyc[i];
        s_saeok = saeok_cyc[i]; s_wr = wr_cyc[i]; s_pat = pat_cyc[i];
    endtask

    task automatic waitAccept(input int i, input int target);
        bit ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (acc_n[i] == target) begin ok = 1'b1; break; end
        end
        checkOutput($sformatf("u%0d accept seen", i), 32'(ok), 32'd1);
    endtask

    task automatic waitRsp(input int i, input int target);
        bit ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rsp_seen[i] == target) begin ok = 1'b1; break; end
        end
        checkOutput($sformatf("u%0d response seen", i), 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus(input int i, input logic we, input logic [3:0] addr,
                                 input logic [15:0] wd, output int latency);
        int n0 = acc_n[i];
        int r0 = rsp_seen[i];
        snap(i);
        req_we = we; req_addr = addr; req_wdata = wd; req_valid[i] = 1'b1;
        waitAccept(i, n0 + 1);
        req_valid[i] = 1'b0;
        req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
        waitRsp(i, r0 + 1);
        latency = rsp_cyc[i] - acc_cyc[i];
        tick();
    endtask

    task automatic backToBack();
        logic [3:0] a [3] = '{4'd5, 4'd9, 4'd2};
        int t [3];
        int n0 = acc_n[0];
        int r0 = rsp_seen[0];
        bit ok;
        req_we = 1'b0; req_addr = a[0]; req_valid[0] = 1'b1;
        for (int idx = 0; idx < 3; idx++) begin
            waitAccept(0, n0 + idx + 1);
            t[idx] = acc_cyc[0];
            if (idx < 2) begin
                req_addr = 4'hF; req_we = 1'b1; req_wdata = 16'hFFFF;
                ok = 1'b0;
                for (int c = 0; c < 30; c++) begin
                    tick();
                    if (req_ready[0]) begin ok = 1'b1; break; end
                    req_addr = 4'($urandom);
                    req_we   = 1'($urandom);
                end
                checkOutput("u0 b2b ready", 32'(ok), 32'd1);
                req_we = 1'b0; req_addr = a[idx + 1];
            end
        end
        req_valid[0] = 1'b0;
        waitRsp(0, r0 + 3);
        tick();
        checkOutput("u0 b2b interval 1", 32'(t[1] - t[0]), 32'd8);
        checkOutput("u0 b2b interval 2", 32'(t[2] - t[1]), 32'd8);
        checkOutput("u0 b2b last rdata", 32'(rdata[0]), 32'h0000BEEF);
    endtask

    initial begin
        int lt;
        int n0;
        int r0;
        fork
            begin : cmp
                int kk;
                logic mwe, v, pre_e, wlon, sae_e, wr_e, rv_e;
                logic [15:0] wl_e;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < NI; i++) begin
                        kk    = k[i];
                        mwe   = m_we[i];
                        v     = int'(m_addr[i]) < RW[i];
                        pre_e = kk >= 1 && kk <= TP[i];
                        wlon  = mwe ? (kk > TP[i] && kk <= TP[i] + TW[i])
                                    : (kk > TP[i] && kk <= TP[i] + TD[i] + TS[i]);
                        wl_e  = (wlon && v) ? (16'd1 << m_addr[i]) : 16'd0;
                        sae_e = !mwe && v && kk > TP[i] + TD[i] && kk <= TP[i] + TD[i] + TS[i];
                        wr_e  = mwe && kk > TP[i] && kk <= TP[i] + TW[i];
                        rv_e  = kk != 0 && kk == lat(i, mwe);
                        checkOutput($sformatf("u%0d req_ready", i), 32'(req_ready[i]), 32'(kk == 0));
                        checkOutput($sformatf("u%0d busy", i), 32'(busy[i]), 32'(kk != 0));
                        checkOutput($sformatf("u%0d precharge_en", i), 32'(pre[i]), 32'(pre_e));
                        checkOutput($sformatf("u%0d wl", i), 32'(wl[i]), 32'(wl_e));
                        checkOutput($sformatf("u%0d sae", i), 32'(sae[i]), 32'(sae_e));
                        checkOutput($sformatf("u%0d wr_drv_en", i), 32'(wrdrv[i]), 32'(wr_e));
                        checkOutput($sformatf("u%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(rv_e));
                        checkOutput($sformatf("u%0d rsp_rdata", i), 32'(rdata[i]), 32'(m_rdata[i]));
                        if (wr_e)
                            checkOutput($sformatf("u%0d bl_wdata", i), 32'(blw[i]), 32'(m_wdata[i]));
                        if (rv_e)
                            checkOutput($sformatf("u%0d rsp_err", i), 32'(rsp_err[i]), 32'(!v));
                        checkOutput($sformatf("u%0d pre/wl overlap", i), 32'(pre[i] && wl[i] != 0), 32'd0);
                        checkOutput($sformatf("u%0d sae without wl", i), 32'(sae[i] && wl[i] == 0), 32'd0);
                        checkOutput($sformatf("u%0d sae/wr overlap", i), 32'(sae[i] && wrdrv[i]), 32'd0);
                        pre_cyc[i]   += int'(pre[i]);
                        wl_cyc[i]    += int'(wl[i] != 0);
                        sae_cyc[i]   += int'(sae[i]);
                        saeok_cyc[i] += int'(sae[i] && wl[i] == 16'h0020);
                        wr_cyc[i]    += int'(wrdrv[i]);
                        pat_cyc[i]   += int'(wrdrv[i] && wl[i] == 16'h0020);
                        if (rsp_valid[i]) begin
                            rsp_seen[i]++;
                            rsp_cyc[i]  = cyc;
                            err_last[i] = rsp_err[i];
                        end
                    end
                end
            end
        join_none

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'b111);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset u0 rsp_rdata", 32'(rdata[0]), 32'd0);
        checkOutput("reset u0 wl", 32'(wl[0]), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        applyStimulus(0, 1'b1, 4'd5, 16'hA5C3, lt);
        checkOutput("u0 write latency", 32'(lt), 32'd5);
        checkOutput("u0 write wl=0020 cycles", 32'(pat_cyc[0] - s_pat), 32'd2);
        checkOutput("u0 write sae cycles", 32'(sae_cyc[0] - s_sae), 32'd0);

        applyStimulus(0, 1'b0, 4'd5, 16'h0000, lt);
        checkOutput("u0 read latency", 32'(lt), 32'd7);
        checkOutput("u0 read rdata", 32'(rdata[0]), 32'h0000A5C3);
        checkOutput("u0 read rsp_err", 32'(err_last[0]), 32'd0);
        checkOutput("u0 read precharge cycles", 32'(pre_cyc[0] - s_pre), 32'd2);
        checkOutput("u0 read wl cycles", 32'(wl_cyc[0] - s_wl), 32'd4);
        checkOutput("u0 read sae cycles", 32'(sae_cyc[0] - s_sae), 32'd1);
        checkOutput("u0 read sae with wl=0020", 32'(saeok_cyc[0] - s_saeok), 32'd1);
        checkOutput("u0 read wr_drv cycles", 32'(wr_cyc[0] - s_wr), 32'd0);

        applyStimulus(0, 1'b1, 4'd9, 16'h1234, lt);
        applyStimulus(0, 1'b1, 4'd2, 16'hBEEF, lt);
        backToBack();

        applyStimulus(1, 1'b1, 4'd3, 16'h0F0F, lt);
        checkOutput("u1 write latency", 32'(lt), 32'd3);
        checkOutput("u1 write wr_drv cycles", 32'(wr_cyc[1] - s_wr), 32'd1);
        applyStimulus(1, 1'b0, 4'd3, 16'h0000, lt);
        checkOutput("u1 read latency", 32'(lt), 32'd4);
        checkOutput("u1 read rdata", 32'(rdata[1]), 32'h00000F0F);
        checkOutput("u1 read precharge cycles", 32'(pre_cyc[1] - s_pre), 32'd1);
        checkOutput("u1 read wl cycles", 32'(wl_cyc[1] - s_wl), 32'd2);
        checkOutput("u1 read sae cycles", 32'(sae_cyc[1] - s_sae), 32'd1);

        applyStimulus(2, 1'b0, 4'd13, 16'h0000, lt);
        checkOutput("u2 bad read latency", 32'(lt), 32'd7);
        checkOutput("u2 bad read rsp_err", 32'(err_last[2]), 32'd1);
        checkOutput("u2 bad read rdata", 32'(rdata[2]), 32'd0);
        checkOutput("u2 bad read wl cycles", 32'(wl_cyc[2] - s_wl), 32'd0);
        applyStimulus(2, 1'b1, 4'd14, 16'h5555, lt);
        checkOutput("u2 bad write latency", 32'(lt), 32'd5);
        checkOutput("u2 bad write rsp_err", 32'(err_last[2]), 32'd1);
        checkOutput("u2 bad write wl cycles", 32'(wl_cyc[2] - s_wl), 32'd0);
        applyStimulus(2, 1'b1, 4'd4, 16'h7777, lt);
        applyStimulus(2, 1'b0, 4'd4, 16'h0000, lt);
        checkOutput("u2 good read rdata", 32'(rdata[2]), 32'h00007777);
        checkOutput("u2 good read rsp_err", 32'(err_last[2]), 32'd0);

        // Abort a read in the development phase with an asynchronous reset.
        n0 = acc_n[0];
        req_we = 1'b0; req_addr = 4'd9; req_valid[0] = 1'b1;
        waitAccept(0, n0 + 1);
        req_valid[0] = 1'b0;
        tick(); tick(); tick();
        checkOutput("u0 wl before abort", 32'(wl[0]), 32'h00000200);
        r0 = rsp_seen[0];
        rst_n = 1'b0;
        #1;
        checkOutput("abort wl", 32'(wl[0]), 32'd0);
        checkOutput("abort sae", 32'(sae[0]), 32'd0);
        checkOutput("abort precharge", 32'(pre[0]), 32'd0);
        checkOutput("abort req_ready", 32'(req_ready[0]), 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("abort no rsp_valid", 32'(rsp_seen[0] - r0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
